// File: rtl/controle_preset.sv
// -----------------------------------------------------------------------------
// controle_preset
//
// Closed-loop preset controller for a downstream 4-bit mod-16 counter. After a
// start request it counts fresh arrivals of the counter at a captured target
// value. On the Nth arrival it raises `preset`. It then holds `preset` until
// the counter leaves the target, or until the hold time runs out. While active
// it also counts 15->0 wraps of the counter, saturating at 255.
//
// Parameters
//   TIMEOUT  maximum number of cycles (1..255) that `preset` waits for the
//            counter to leave the target; preset is high TIMEOUT+1 cycles
//            when the counter never moves.
//
// Ports
//   clock    in   1  system clock, rising edge
//   reset    in   1  synchronous, active-high reset
//   counter  in   4  current value of the downstream counter
//   start    in   1  one-cycle arm request (ignored while busy)
//   target   in   4  counter value to fire on (captured at start)
//   hits     in   4  arrivals needed before firing, 0 treated as 1
//   preset   out  1  registered preset drive to the counter
//   busy     out  1  registered, high while WATCH or FIRE
//   done     out  1  registered one-cycle pulse: counter left the target
//   timeout  out  1  registered one-cycle pulse: FIRE hold expired
//   wraps    out  8  registered saturating count of 15->0 wraps while busy
// -----------------------------------------------------------------------------
module controle_preset #(
    parameter int TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] counter,
    input  logic       start,
    input  logic [3:0] target,
    input  logic [3:0] hits,
    output logic       preset,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic [7:0] wraps
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WATCH = 2'd1,
        FIRE  = 2'd2,
        BAD   = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT);

    // Saturating 8-bit increment used by the wrap counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        if (val == 8'hFF) begin
            return val;
        end
        return val + 8'd1;
    endfunction

    state_t     state, state_n;
    logic [3:0] prev, prev_n;
    logic [3:0] target_r, target_n;
    logic [3:0] hits_r, hits_n;
    logic [3:0] match_cnt, match_n;
    logic [7:0] hold_cnt, hold_n;
    logic [7:0] wraps_n;
    logic       preset_n, busy_n, done_n, timeout_n;

    logic       arrival;
    logic       wrap;
    logic [3:0] match_inc;

    // An arrival is counted only on the cycle the counter steps onto the
    // target, so a counter parked at the target counts once.
    assign arrival   = (counter == target_r) && (prev != target_r);
    assign wrap      = (prev == 4'hF) && (counter == 4'h0);
    assign match_inc = match_cnt + 4'd1;

    always_comb begin
        state_n   = state;
        prev_n    = counter;
        target_n  = target_r;
        hits_n    = hits_r;
        match_n   = match_cnt;
        hold_n    = hold_cnt;
        wraps_n   = wraps;
        preset_n  = 1'b0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        timeout_n = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    target_n = target;
                    hits_n   = (hits == 4'd0) ? 4'd1 : hits;
                    match_n  = 4'd0;
                    wraps_n  = 8'd0;
                    busy_n   = 1'b1;
                    state_n  = WATCH;
                end
            end

            WATCH: begin
                busy_n = 1'b1;
                if (wrap) begin
                    wraps_n = sat_inc8(wraps);
                end
                if (arrival) begin
                    match_n = match_inc;
                    if (match_inc == hits_r) begin
                        preset_n = 1'b1;
                        hold_n   = 8'd0;
                        state_n  = FIRE;
                    end
                end
            end

            FIRE: begin
                if (wrap) begin
                    wraps_n = sat_inc8(wraps);
                end
                if (counter != target_r) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (hold_cnt == HOLD_LIMIT) begin
                    // hold_cnt only starts counting on the cycle after preset
                    // rose, hence the TIMEOUT+1 cycle high time.
                    timeout_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    hold_n   = hold_cnt + 8'd1;
                    preset_n = 1'b1;
                    busy_n   = 1'b1;
                end
            end

            default: begin
                // Unused encoding: recover to IDLE with everything cleared.
                wraps_n = 8'd0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            prev      <= 4'd0;
            target_r  <= 4'd0;
            hits_r    <= 4'd0;
            match_cnt <= 4'd0;
            hold_cnt  <= 8'd0;
            wraps     <= 8'd0;
            preset    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            prev      <= prev_n;
            target_r  <= target_n;
            hits_r    <= hits_n;
            match_cnt <= match_n;
            hold_cnt  <= hold_n;
            wraps     <= wraps_n;
            preset    <= preset_n;
            busy      <= busy_n;
            done      <= done_n;
            timeout   <= timeout_n;
        end
    end

endmodule

// File: tb/tb_controle_preset.sv
// -----------------------------------------------------------------------------
// tb_controle_preset
//
// Directed, self-checking bench for controle_preset (TIMEOUT = 15). Inputs are
// driven 1 ns after the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_controle_preset;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] counter;
    logic       start;
    logic [3:0] target;
    logic [3:0] hits;
    logic       preset;
    logic       busy;
    logic       done;
    logic       timeout;
    logic [7:0] wraps;

    int tests  = 0;
    int failed = 0;
    int high_cycles;

    controle_preset #(.TIMEOUT(15)) dut (
        .clock   (clock),
        .reset   (reset),
        .counter (counter),
        .start   (start),
        .target  (target),
        .hits    (hits),
        .preset  (preset),
        .busy    (busy),
        .done    (done),
        .timeout (timeout),
        .wraps   (wraps)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic p, input logic b,
                            input logic d, input logic t, input logic [7:0] w);
        chk({tag, ".preset"},  {7'd0, preset},  {7'd0, p});
        chk({tag, ".busy"},    {7'd0, busy},    {7'd0, b});
        chk({tag, ".done"},    {7'd0, done},    {7'd0, d});
        chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, t});
        chk({tag, ".wraps"},   wraps,           w);
    endtask

    initial begin
        reset   = 1'b1;
        counter = 4'd0;
        start   = 1'b0;
        target  = 4'd0;
        hits    = 4'd0;
        step();
        step();
        chk_outs("reset", 0, 0, 0, 0, 8'd0);

        // Basic fire: target 2, hits 1, counter 0,1,2 then 5.
        reset  = 1'b0;
        target = 4'd2;
        hits   = 4'd1;
        start  = 1'b1;
        step();
        start = 1'b0;
        chk_outs("basic_start", 0, 1, 0, 0, 8'd0);
        counter = 4'd1;
        step();
        chk("basic_c1.preset", {7'd0, preset}, 8'd0);
        counter = 4'd2;
        step();
        chk_outs("basic_fire", 1, 1, 0, 0, 8'd0);
        counter = 4'd5;
        step();
        chk_outs("basic_release", 0, 0, 1, 0, 8'd0);
        step();
        chk_outs("basic_after", 0, 0, 0, 0, 8'd0);

        // Multiple hits and a wrap: target 3, hits 2, each value held 2 cycles.
        counter = 4'd0;
        target  = 4'd3;
        hits    = 4'd2;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 19; i++) begin
            counter = 4'(i);
            step();
            step();
            if (i == 3) chk("multi_first3.preset", {7'd0, preset}, 8'd0);
        end
        chk_outs("multi_before2nd", 0, 1, 0, 0, 8'd1);
        counter = 4'd3;
        step();
        chk_outs("multi_fire", 1, 1, 0, 0, 8'd1);
        counter = 4'd4;
        step();
        chk_outs("multi_release", 0, 0, 1, 0, 8'd1);
        step();
        chk("multi_hold.wraps", wraps, 8'd1);

        // Counter already at target when armed, hits 0 -> needs the next arrival.
        counter = 4'd7;
        target  = 4'd7;
        hits    = 4'd0;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk_outs("pre_start", 0, 1, 0, 0, 8'd0);
        step();
        chk("pre_parked.preset", {7'd0, preset}, 8'd0);
        for (int v = 8; v < 23; v++) begin
            counter = 4'(v);
            step();
        end
        chk_outs("pre_before", 0, 1, 0, 0, 8'd1);
        counter = 4'd7;
        step();
        chk_outs("pre_fire", 1, 1, 0, 0, 8'd1);

        // Timeout: counter parked at 7, preset must stay high 16 cycles total.
        high_cycles = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (preset !== 1'b1) break;
            high_cycles++;
        end
        chk("timeout.high_cycles", 8'(high_cycles), 8'd16);
        chk_outs("timeout_pulse", 0, 0, 0, 1, 8'd1);
        step();
        chk_outs("timeout_after", 0, 0, 0, 0, 8'd1);

        // Wrap and arrival in the same cycle: target 0.
        counter = 4'd14;
        target  = 4'd0;
        hits    = 4'd1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        counter = 4'd15;
        step();
        chk_outs("wraparr_pre", 0, 1, 0, 0, 8'd0);
        counter = 4'd0;
        step();
        chk_outs("wraparr_fire", 1, 1, 0, 0, 8'd1);
        counter = 4'd1;
        step();
        chk_outs("wraparr_release", 0, 0, 1, 0, 8'd1);

        // Reset in the middle of FIRE, then a normal start with an ignored
        // second start (target 9) during WATCH.
        counter = 4'd0;
        target  = 4'd1;
        hits    = 4'd1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        counter = 4'd1;
        step();
        chk("rst_fire.preset", {7'd0, preset}, 8'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_outs("rst_mid_fire", 0, 0, 0, 0, 8'd0);
        step();
        chk_outs("rst_settle", 0, 0, 0, 0, 8'd0);

        counter = 4'd2;
        target  = 4'd4;
        hits    = 4'd1;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk_outs("ign_start", 0, 1, 0, 0, 8'd0);
        counter = 4'd9;
        target  = 4'd9;
        hits    = 4'd1;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk_outs("ign_at9", 0, 1, 0, 0, 8'd0);
        counter = 4'd4;
        step();
        chk_outs("ign_fire4", 1, 1, 0, 0, 8'd0);
        counter = 4'd9;
        step();
        chk_outs("ign_release", 0, 0, 1, 0, 8'd0);

        // Wrap counter saturation: target never visited, 260 wraps.
        counter = 4'd0;
        target  = 4'd8;
        hits    = 4'd1;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 260; i++) begin
            counter = 4'd15;
            step();
            counter = 4'd0;
            step();
            if (i == 9) chk("sat_10.wraps", wraps, 8'd10);
        end
        chk_outs("sat_255", 0, 1, 0, 0, 8'd255);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_outs("sat_reset", 0, 0, 0, 0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
